// File: rtl/morse_pkg.sv
// morse_pkg: Morse decoder state enum, letter codes and per-letter symbol patterns (dot=0, dash=1, first symbol at bit 0)
package morse_pkg;
    typedef enum logic [1:0] {IDLE, MARK, SPACE} morse_state_t;
    localparam logic [2:0] LTR_A = 3'd0;
    localparam logic [2:0] LTR_B = 3'd1;
    localparam logic [2:0] LTR_C = 3'd2;
    localparam logic [2:0] LTR_D = 3'd3;
    localparam logic [2:0] LTR_E = 3'd4;
    localparam logic [2:0] LTR_F = 3'd5;
    localparam logic [2:0] LTR_G = 3'd6;
    localparam logic [2:0] LTR_H = 3'd7;
    localparam logic [2:0] LTR_CODE [8] = '{LTR_A, LTR_B, LTR_C, LTR_D, LTR_E, LTR_F, LTR_G, LTR_H};
    localparam logic [3:0] LTR_SYM [8] = '{4'b0010, 4'b0001, 4'b0101, 4'b0001, 4'b0000, 4'b0100, 4'b0011, 4'b0000};
    localparam logic [2:0] LTR_LEN [8] = '{3'd2, 3'd4, 3'd4, 3'd3, 3'd1, 3'd4, 3'd3, 3'd4};
endpackage

// File: rtl/morse_decoder_if.sv
// morse_decoder_if: serial bit stream in, decoded letter out; master = bit source, slave = decoder
interface morse_decoder_if;
    logic       DotDashIn;
    logic       NewBitIn;
    logic [2:0] LetterOut;
    logic       LetterValid;
    logic       LetterError;
    logic       Busy;
    modport master (output DotDashIn, NewBitIn, input LetterOut, LetterValid, LetterError, Busy);
    modport slave (input DotDashIn, NewBitIn, output LetterOut, LetterValid, LetterError, Busy);
endinterface

// File: rtl/morse_lookup.sv
// morse_lookup: maps (sym, symCnt) to a letter code; match=0 when no letter fits
module morse_lookup
    import morse_pkg::*;
(
    input  logic [3:0] sym,
    input  logic [2:0] symCnt,
    output logic [2:0] code,
    output logic       match
);
    // symbol bits beyond symCnt are always zero, so a full-width compare is exact
    always_comb begin
        code  = LTR_A;
        match = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (symCnt == LTR_LEN[i] && sym == LTR_SYM[i]) begin
                code  = LTR_CODE[i];
                match = 1'b1;
            end
        end
    end
endmodule

// File: rtl/morse_decoder.sv
// morse_decoder: classifies mark/space runs of a one-bit-per-strobe stream into letters A..H
// ports: ClockIn, ResetN (async active-low), bus.slave (DotDashIn/NewBitIn in; LetterOut/LetterValid/LetterError/Busy out)
module morse_decoder
    import morse_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 500,
    parameter int LETTER_GAP      = 3,
    parameter int TIMEOUT_CYCLES  = 2 * CLOCK_FREQUENCY
) (
    input logic            ClockIn,
    input logic            ResetN,
    morse_decoder_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    morse_state_t  state, state_nx;
    logic [2:0]    mark_cnt, space_cnt, sym_cnt, code;
    logic [3:0]    sym;
    logic [TW-1:0] tmr;
    logic          err, match, strobe, b, tmo, gap_done, done, done_err;
    assign strobe = bus.NewBitIn;
    assign b      = bus.DotDashIn;
    morse_lookup u_lookup (.sym(sym), .symCnt(sym_cnt), .code(code), .match(match));
    always_ff @(posedge ClockIn or negedge ResetN)
        if (!ResetN) state <= IDLE;
        else state <= state_nx;
    // the timeout fires on the idle cycle whose count reaches TIMEOUT_CYCLES; a strobe on it wins
    always_comb begin
        tmo      = state != IDLE && !strobe && tmr == TW'(TIMEOUT_CYCLES - 1);
        gap_done = state == SPACE && strobe && !b && space_cnt == 3'(LETTER_GAP - 1);
        state_nx = tmo ? IDLE : !strobe ? state : b ? MARK :
                   state == MARK ? SPACE : (state == SPACE && !gap_done) ? SPACE : IDLE;
    end
    always_comb begin
        done     = tmo || gap_done;
        done_err = state == MARK || err || !match;
        bus.Busy = state != IDLE;
    end
    always_ff @(posedge ClockIn or negedge ResetN)
        if (!ResetN) begin
            bus.LetterOut   <= LTR_A;
            bus.LetterValid <= 1'b0;
            bus.LetterError <= 1'b0;
            mark_cnt        <= '0;
            space_cnt       <= '0;
            sym_cnt         <= '0;
            sym             <= '0;
            err             <= 1'b0;
            tmr             <= '0;
        end else begin
            bus.LetterValid <= done && !done_err;
            bus.LetterError <= done && done_err;
            if (done) bus.LetterOut <= done_err ? LTR_A : code;
            tmr <= (strobe || done) ? '0 : (state != IDLE && tmr != TW'(TIMEOUT_CYCLES)) ? tmr + 1'b1 : tmr;
            if (done) begin
                mark_cnt  <= '0;
                space_cnt <= '0;
                sym_cnt   <= '0;
                sym       <= '0;
                err       <= 1'b0;
            end else if (strobe) begin
                if (b) mark_cnt <= state != MARK ? 3'd1 : mark_cnt == 3'd4 ? 3'd4 : mark_cnt + 3'd1;
                else if (state == MARK) begin
                    space_cnt <= 3'd1;
                    if (!(mark_cnt == 3'd1 || mark_cnt == 3'd3) || sym_cnt == 3'd4) err <= 1'b1;
                    else begin
                        sym[sym_cnt[1:0]] <= mark_cnt == 3'd3;
                        sym_cnt           <= sym_cnt + 3'd1;
                    end
                end else if (state == SPACE) space_cnt <= space_cnt + 3'd1;
            end
        end
endmodule
